// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The digit history is built only when KEYPAD_HISTORY_EN is defined.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    localparam logic [KEY_ROWS-1:0] ROWS_RST = 4'b1110;
    localparam logic [KEY_COLS-1:0] CS_RST   = 4'hF;

    // True when exactly one column is pulled low
    function automatic logic one_cold(input logic [KEY_COLS-1:0] v);
        logic [KEY_COLS-1:0] n;
        n = ~v;
        return (n != '0) && ((n & (n - 1'b1)) == '0);
    endfunction

    function automatic logic [1:0] col_idx(input logic [KEY_COLS-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_COLS; i++)
            if (!v[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad columns.
// Resets to all-high, i.e. no key pressed.
module col_sync
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_COLS-1:0] d,
    output logic [KEY_COLS-1:0] q
);

    logic [KEY_COLS-1:0] s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= CS_RST;
            q  <= CS_RST;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with debounce and hex key code output.
// Define KEYPAD_HISTORY_EN to build the 8-digit history register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_COLS-1:0] cols,
    output logic [KEY_ROWS-1:0] rows,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic [31:0]         digits
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CNT);

    logic [KEY_COLS-1:0] cs;
    logic [KEY_COLS-1:0] pat;
    logic [1:0]          r;
    logic [1:0]          c;
    logic [DW-1:0]       dwell;
    logic [CW-1:0]       cnt;
    state_t              state;
    logic                accept;

    col_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cols),
        .q   (cs)
    );

    assign rows   = ~(KEY_ROWS'(1) << r);
    assign accept = (state == DEBOUNCE) && (cs == pat) && (cnt == CNT_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            r         <= '0;
            c         <= '0;
            pat       <= CS_RST;
            dwell     <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (one_cold(cs)) begin
                            pat   <= cs;
                            c     <= col_idx(cs);
                            cnt   <= '0;
                            state <= DEBOUNCE;
                        end else begin
                            r <= r + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (cs != pat) begin
                        dwell <= '0;
                        state <= SCAN;
                    end else if (cnt == CNT_DONE) begin
                        key_code  <= {r, c};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        cnt       <= '0;
                        state     <= HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    // Any low column, even from another key, restarts release timing
                    if (cs != CS_RST) begin
                        cnt <= '0;
                    end else if (cnt == CNT_DONE) begin
                        key_held <= 1'b0;
                        r        <= r + 2'd1;
                        dwell    <= '0;
                        cnt      <= '0;
                        state    <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

`ifdef KEYPAD_HISTORY_EN
    always_ff @(posedge clk) begin
        if (rst)
            digits <= '0;
        else if (accept)
            digits <= {digits[27:0], r, c};
    end
`else
    assign digits = '0;
`endif

endmodule
